// File: rtl/fetch_pkg.sv
// Shared fetch-unit types: opcodes, predictor counter encodings,
// fetch FSM states, queue entry layout and immediate helpers.
package fetch_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALT
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } iq_entry_t;

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] c,
                                            input logic       t);
        if (t) begin
            return (c == ST) ? ST : c + 2'd1;
        end
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and dispatch.
// Flush wins over push and pop; pops of an empty queue are ignored.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     push,
    input  iq_entry_t                push_data,
    input  logic                     pop,
    output iq_entry_t                head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    iq_entry_t         mem_q [DEPTH];
    iq_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // Next pointer/count/storage state from push, pop and flush.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_push = push && (count_q != CW'(DEPTH));
        do_pop  = pop && (count_q != '0);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + 1'b1;
            end
            if (do_pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Queue state registers, frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (en) begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[head_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/ifetch_bp.sv
// Instruction fetch with 2-bit BHT prediction, decoupling queue
// and squash-safe redirect handling.
module ifetch_bp
    import fetch_pkg::*;
#(
    parameter int          BHT_IDX_W = 7,
    parameter int          IQ_DEPTH  = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_inst,
    output logic        iq_valid,
    input  logic        iq_ready,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred_taken,
    output logic [31:0] iq_pred_pc,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic        br_taken,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int CW    = $clog2(IQ_DEPTH) + 1;

    state_t               state_q, state_d;
    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic                 discard_q, discard_d;
    logic [1:0]           bht_q [BHT_N];
    logic [1:0]           bht_d [BHT_N];

    logic [BHT_IDX_W-1:0] rd_idx;
    logic [BHT_IDX_W-1:0] wr_idx;
    logic [1:0]           rd_ctr;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 is_br_t;
    logic                 pred_taken;
    logic [31:0]          pred_pc;

    logic                 iq_push;
    logic                 iq_pop;
    iq_entry_t            iq_entry;
    iq_entry_t            iq_head;
    logic [CW-1:0]        iq_cnt;
    logic                 unused_ok;

    assign rd_idx  = fetch_pc_q[BHT_IDX_W+1:2];
    assign wr_idx  = br_pc[BHT_IDX_W+1:2];
    assign rd_ctr  = bht_q[rd_idx];
    assign is_jal  = (ic_inst[6:0] == OP_JAL);
    assign is_jalr = (ic_inst[6:0] == OP_JALR);
    assign is_br_t = (ic_inst[6:0] == OP_BRANCH) && rd_ctr[1];

    assign unused_ok = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0]};

    // Predicted next PC of the instruction returning from the icache.
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = fetch_pc_q + 32'd4;
        unique case (1'b1)
            is_jal: begin
                pred_taken = 1'b1;
                pred_pc    = fetch_pc_q + imm_j(ic_inst);
            end
            is_br_t: begin
                pred_taken = 1'b1;
                pred_pc    = fetch_pc_q + imm_b(ic_inst);
            end
            default: ;
        endcase
    end

    // Counter training from the resolve port, independent of redirects.
    always_comb begin
        bht_d = bht_q;
        if (br_valid) begin
            bht_d[wr_idx] = ctr_next(bht_q[wr_idx], br_taken);
        end
    end

    // Fetch FSM: request issue, response push and redirect squash.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        iq_push    = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            if (state_q == WAIT && !ic_valid) begin
                state_d   = WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (iq_cnt < CW'(IQ_DEPTH)) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (ic_valid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            iq_push = 1'b1;
                            if (is_jalr) begin
                                state_d = HALT;
                            end else begin
                                fetch_pc_d = pred_pc;
                                state_d    = IDLE;
                            end
                        end
                    end
                end
                HALT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    // Branch history table storage, weakly not-taken after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= WNT;
            end
        end else if (rdy) begin
            bht_q <= bht_d;
        end
    end

    assign iq_entry = '{
        inst:       ic_inst,
        pc:         fetch_pc_q,
        pred_taken: pred_taken,
        pred_pc:    pred_pc
    };

    assign iq_pop = iq_ready && !redirect_valid;

    fetch_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .flush     (redirect_valid),
        .push      (iq_push),
        .push_data (iq_entry),
        .pop       (iq_pop),
        .head      (iq_head),
        .valid     (iq_valid),
        .count     (iq_cnt)
    );

    assign ic_req        = (state_q == WAIT);
    assign ic_addr       = fetch_pc_q;
    assign iq_inst       = iq_head.inst;
    assign iq_pc         = iq_head.pc;
    assign iq_pred_taken = iq_valid && iq_head.pred_taken;
    assign iq_pred_pc    = iq_head.pred_pc;

endmodule

// File: tb/tb_ifetch_bp.sv
// Directed bench for ifetch_bp: prediction vector table plus
// hand sequences for halt, backpressure and redirect corners.
module tb_ifetch_bp;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] JAL_100 = 32'h1000_006F;
    localparam logic [31:0] JAL_M4  = 32'hFFDF_F06F;
    localparam logic [31:0] BEQ_M16 = 32'hFE00_08E3;
    localparam logic [31:0] BEQ_P8  = 32'h0000_0463;
    localparam logic [31:0] JALR_X1 = 32'h0000_8067;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_inst;
    logic        iq_valid;
    logic        iq_ready;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pred_taken;
    logic [31:0] iq_pred_pc;
    logic        br_valid;
    logic [31:0] br_pc;
    logic        br_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    ifetch_bp #(
        .BHT_IDX_W (7),
        .IQ_DEPTH  (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_valid       (ic_valid),
        .ic_inst        (ic_inst),
        .iq_valid       (iq_valid),
        .iq_ready       (iq_ready),
        .iq_inst        (iq_inst),
        .iq_pc          (iq_pc),
        .iq_pred_taken  (iq_pred_taken),
        .iq_pred_pc     (iq_pred_pc),
        .br_valid       (br_valid),
        .br_pc          (br_pc),
        .br_taken       (br_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] tpc;
        int          n_t;
        int          n_nt;
        logic        exp_pt;
        logic [31:0] exp_pp;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        rdy            = 1'b1;
        ic_valid       = 1'b0;
        ic_inst        = 32'h0;
        iq_ready       = 1'b0;
        br_valid       = 1'b0;
        br_pc          = 32'h0;
        br_taken       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!ic_req && n < 30) begin
            tick();
            n++;
        end
        chk({nm, "_req"}, {31'b0, ic_req}, 32'd1);
    endtask

    task automatic respond(input logic [31:0] inst);
        ic_valid = 1'b1;
        ic_inst  = inst;
        tick();
        ic_valid = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input int n,
                         input logic t);
        for (int k = 0; k < n; k++) begin
            br_valid = 1'b1;
            br_pc    = pc;
            br_taken = t;
            tick();
        end
        br_valid = 1'b0;
    endtask

    initial begin
        int   resp;
        logic seen;
        logic [31:0] got [$];

        vt[0]  = '{32'h0,        NOP,     32'h0,   0, 0, 1'b0, 32'h4};
        vt[1]  = '{32'h8,        JAL_100, 32'h8,   0, 0, 1'b1, 32'h108};
        vt[2]  = '{32'h10,       BEQ_M16, 32'h10,  0, 0, 1'b0, 32'h14};
        vt[3]  = '{32'h10,       BEQ_M16, 32'h10,  2, 0, 1'b1, 32'h0};
        vt[4]  = '{32'h10,       BEQ_M16, 32'h10,  1, 0, 1'b1, 32'h0};
        vt[5]  = '{32'h10,       BEQ_M16, 32'h10,  0, 1, 1'b0, 32'h14};
        vt[6]  = '{32'h100,      BEQ_P8,  32'h100, 3, 0, 1'b1, 32'h108};
        vt[7]  = '{32'h0,        JAL_M4,  32'h0,   0, 0, 1'b1, 32'hFFFF_FFFC};
        vt[8]  = '{32'hFFFF_FFFC, NOP,    32'h0,   0, 0, 1'b0, 32'h0};
        vt[9]  = '{32'h10,       BEQ_M16, 32'h10,  0, 3, 1'b0, 32'h14};
        vt[10] = '{32'h10,       BEQ_M16, 32'h10,  4, 1, 1'b1, 32'h0};
        vt[11] = '{32'h10,       BEQ_M16, 32'h210, 2, 0, 1'b1, 32'h0};
        vt[12] = '{32'h8,        JAL_100, 32'h8,   0, 3, 1'b1, 32'h108};

        // reset values and first request
        reset_dut();
        chk("rst_ic_req", {31'b0, ic_req}, 32'd0);
        chk("rst_iq_valid", {31'b0, iq_valid}, 32'd0);
        chk("rst_pred_taken", {31'b0, iq_pred_taken}, 32'd0);
        tick();
        chk("first_req", {31'b0, ic_req}, 32'd1);
        chk("first_addr", ic_addr, 32'h0);

        // vector table: one fetch each from a clean reset
        for (int i = 0; i < 13; i++) begin
            reset_dut();
            redirect_to(vt[i].pc);
            train(vt[i].tpc, vt[i].n_t, 1'b1);
            train(vt[i].tpc, vt[i].n_nt, 1'b0);
            wait_req($sformatf("v%0d", i));
            chk($sformatf("v%0d_addr", i), ic_addr, vt[i].pc);
            respond(vt[i].inst);
            chk($sformatf("v%0d_valid", i), {31'b0, iq_valid}, 32'd1);
            chk($sformatf("v%0d_pc", i), iq_pc, vt[i].pc);
            chk($sformatf("v%0d_inst", i), iq_inst, vt[i].inst);
            chk($sformatf("v%0d_pt", i), {31'b0, iq_pred_taken},
                {31'b0, vt[i].exp_pt});
            chk($sformatf("v%0d_pp", i), iq_pred_pc, vt[i].exp_pp);
            wait_req($sformatf("v%0d_next", i));
            chk($sformatf("v%0d_next_addr", i), ic_addr, vt[i].exp_pp);
        end

        // NOP stream with a free-running consumer
        reset_dut();
        iq_ready = 1'b1;
        for (int c = 0; c < 60 && got.size() < 4; c++) begin
            if (iq_valid) begin
                got.push_back(iq_pc);
                chk("stream_pt", {31'b0, iq_pred_taken}, 32'd0);
            end
            if (ic_req && !ic_valid) begin
                ic_valid = 1'b1;
                ic_inst  = NOP;
            end else begin
                ic_valid = 1'b0;
            end
            tick();
        end
        ic_valid = 1'b0;
        iq_ready = 1'b0;
        chk("stream_cnt", got.size(), 32'd4);
        for (int k = 0; k < got.size(); k++) begin
            chk($sformatf("stream_pc%0d", k), got[k], 32'(k * 4));
        end

        // JALR halts fetch until redirected
        reset_dut();
        redirect_to(32'h20);
        wait_req("jalr");
        respond(JALR_X1);
        chk("jalr_valid", {31'b0, iq_valid}, 32'd1);
        chk("jalr_pc", iq_pc, 32'h20);
        chk("jalr_pt", {31'b0, iq_pred_taken}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            seen |= ic_req;
        end
        chk("jalr_halt_req", {31'b0, seen}, 32'd0);
        chk("jalr_hold_addr", ic_addr, 32'h20);
        redirect_to(32'h40);
        chk("jalr_flush", {31'b0, iq_valid}, 32'd0);
        wait_req("jalr_redir");
        chk("jalr_redir_addr", ic_addr, 32'h40);

        // backpressure: queue fills, one pop allows one request
        reset_dut();
        resp = 0;
        for (int c = 0; c < 60; c++) begin
            if (ic_req && !ic_valid) begin
                ic_valid = 1'b1;
                ic_inst  = NOP;
                resp++;
            end else begin
                ic_valid = 1'b0;
            end
            tick();
        end
        ic_valid = 1'b0;
        chk("full_resp", resp, 32'd4);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            seen |= ic_req;
        end
        chk("full_no_req", {31'b0, seen}, 32'd0);
        chk("full_head", iq_pc, 32'h0);
        iq_ready = 1'b1;
        tick();
        iq_ready = 1'b0;
        chk("pop_head", iq_pc, 32'h4);
        resp = 0;
        for (int c = 0; c < 30; c++) begin
            if (ic_req && !ic_valid) begin
                if (resp == 0) begin
                    chk("pop_req_addr", ic_addr, 32'h10);
                end
                ic_valid = 1'b1;
                ic_inst  = NOP;
                resp++;
            end else begin
                ic_valid = 1'b0;
            end
            tick();
        end
        ic_valid = 1'b0;
        chk("pop_one_req", resp, 32'd1);

        // redirect while waiting; stale response arrives later
        reset_dut();
        tick();
        redirect_to(32'h80);
        chk("stale_wait", {31'b0, ic_req}, 32'd1);
        tick();
        respond(JAL_100);
        chk("stale_drop", {31'b0, iq_valid}, 32'd0);
        wait_req("stale");
        chk("stale_addr", ic_addr, 32'h80);
        respond(NOP);
        chk("stale_new_valid", {31'b0, iq_valid}, 32'd1);
        chk("stale_new_pc", iq_pc, 32'h80);

        // redirect in the same cycle as the response
        reset_dut();
        tick();
        ic_valid       = 1'b1;
        ic_inst        = NOP;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        ic_valid       = 1'b0;
        redirect_valid = 1'b0;
        chk("coinc_drop", {31'b0, iq_valid}, 32'd0);
        wait_req("coinc");
        chk("coinc_addr", ic_addr, 32'h200);
        respond(NOP);
        chk("coinc_valid", {31'b0, iq_valid}, 32'd1);
        chk("coinc_pc", iq_pc, 32'h200);

        // rdy low freezes the FSM
        reset_dut();
        rdy = 1'b0;
        tick();
        tick();
        tick();
        chk("rdy_freeze", {31'b0, ic_req}, 32'd0);
        rdy = 1'b1;
        tick();
        chk("rdy_resume", {31'b0, ic_req}, 32'd1);

        // same-cycle training does not affect this prediction
        reset_dut();
        redirect_to(32'h10);
        wait_req("same");
        br_valid = 1'b1;
        br_pc    = 32'h10;
        br_taken = 1'b1;
        respond(BEQ_M16);
        br_valid = 1'b0;
        chk("same_pt_old", {31'b0, iq_pred_taken}, 32'd0);
        wait_req("same_next");
        chk("same_next_addr", ic_addr, 32'h14);
        respond(NOP);
        redirect_to(32'h10);
        wait_req("same_again");
        respond(BEQ_M16);
        chk("same_pt_new", {31'b0, iq_pred_taken}, 32'd1);
        chk("same_pp_new", iq_pred_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
